instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 36 +++
 rtl/instr_fetch_ir_field_split.sv | 25 ++
 rtl/instr_fetch.sv | 111 +++++++++++
 tb/tb_instr_fetch.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, reset PC
// default and the bit positions of the instruction word fields.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        FLUSH
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned OPCODE_W   = 6;
    localparam int unsigned RS_LSB     = 21;
    localparam int unsigned RS_W       = 5;
    localparam int unsigned RT_LSB     = 16;
    localparam int unsigned RT_W       = 5;
    localparam int unsigned RD_LSB     = 11;
    localparam int unsigned RD_W       = 5;
    localparam int unsigned SHAMT_LSB  = 6;
    localparam int unsigned SHAMT_W    = 5;
    localparam int unsigned FUNCT_LSB  = 0;
    localparam int unsigned FUNCT_W    = 6;
    localparam int unsigned IMM16_LSB  = 0;
    localparam int unsigned IMM16_W    = 16;
    localparam int unsigned TARGET_LSB = 0;
    localparam int unsigned TARGET_W   = 26;

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_ir_field_split.sv
// Combinational decode of the instruction register into its named fields.
module ir_field_split
    import instr_fetch_pkg::*;
(
    input  logic [31:0]           ir,
    output logic [OPCODE_W-1:0]   opcode,
    output logic [RS_W-1:0]       rs,
    output logic [RT_W-1:0]       rt,
    output logic [RD_W-1:0]       rd,
    output logic [SHAMT_W-1:0]    shamt,
    output logic [FUNCT_W-1:0]    funct,
    output logic [IMM16_W-1:0]    imm16,
    output logic [TARGET_W-1:0]   target
);

    assign opcode = ir[OPCODE_LSB +: OPCODE_W];
    assign rs     = ir[RS_LSB     +: RS_W];
    assign rt     = ir[RT_LSB     +: RT_W];
    assign rd     = ir[RD_LSB     +: RD_W];
    assign shamt  = ir[SHAMT_LSB  +: SHAMT_W];
    assign funct  = ir[FUNCT_LSB  +: FUNCT_W];
    assign imm16  = ir[IMM16_LSB  +: IMM16_W];
    assign target = ir[TARGET_LSB +: TARGET_W];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues word requests to instruction memory,
// latches the returned word into the IR and hands it downstream, honouring
// control-flow redirects that may arrive at any point of a request.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           pc_in,
    input  logic                  pc_load,
    output logic                  mem_req,
    output logic [31:0]           mem_addr,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata,
    output logic                  ir_valid,
    input  logic                  ir_ready,
    output logic [31:0]           ir_out,
    output logic [31:0]           ir_pc,
    output logic [31:0]           pc_plus4,
    output logic [OPCODE_W-1:0]   opcode_ir,
    output logic [RS_W-1:0]       rs_ir,
    output logic [RT_W-1:0]       rt_ir,
    output logic [RD_W-1:0]       rd_ir,
    output logic [SHAMT_W-1:0]    shamt_ir,
    output logic [FUNCT_W-1:0]    funct_ir,
    output logic [IMM16_W-1:0]    imm16_ir,
    output logic [TARGET_W-1:0]   target_ir
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  req_addr;
    logic [31:0]  load_target;
    logic [31:0]  next_pc;

    assign load_target = word_align(pc_in);
    // PC to be used for a request issued at this edge, including a same-cycle redirect.
    assign next_pc     = pc_load ? load_target : pc;

    assign mem_req  = (state == FETCH) || (state == FLUSH);
    assign mem_addr = req_addr;
    assign ir_valid = (state == HOLD);
    assign pc_plus4 = ir_pc + 32'd4;

    // Fetch FSM together with PC, request address and IR registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            ir_out   <= '0;
            ir_pc    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    pc       <= next_pc;
                    req_addr <= next_pc;
                    state    <= FETCH;
                end
                FETCH: begin
                    if (mem_ack && !pc_load) begin
                        ir_out <= mem_rdata;
                        ir_pc  <= req_addr;
                        pc     <= req_addr + 32'd4;
                        state  <= HOLD;
                    end else if (mem_ack) begin
                        // Data belongs to the old path; reissue immediately at the target.
                        pc       <= load_target;
                        req_addr <= load_target;
                    end else if (pc_load) begin
                        pc    <= load_target;
                        state <= FLUSH;
                    end
                end
                HOLD: begin
                    if (ir_ready || pc_load) begin
                        pc       <= next_pc;
                        req_addr <= next_pc;
                        state    <= FETCH;
                    end
                end
                FLUSH: begin
                    // The stale request must still complete before a new one is issued.
                    if (pc_load) begin
                        pc <= load_target;
                    end
                    if (mem_ack) begin
                        req_addr <= next_pc;
                        state    <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    ir_field_split u_field_split (
        .ir     (ir_out),
        .opcode (opcode_ir),
        .rs     (rs_ir),
        .rt     (rt_ir),
        .rd     (rd_ir),
        .shamt  (shamt_ir),
        .funct  (funct_ir),
        .imm16  (imm16_ir),
        .target (target_ir)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by
// randomized traffic, compared against a transaction-level reference model.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in;
    logic        pc_load;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] ir_out;
    logic [31:0] ir_pc;
    logic [31:0] pc_plus4;
    logic [5:0]  opcode_ir;
    logic [4:0]  rs_ir;
    logic [4:0]  rt_ir;
    logic [4:0]  rd_ir;
    logic [4:0]  shamt_ir;
    logic [5:0]  funct_ir;
    logic [15:0] imm16_ir;
    logic [25:0] target_ir;

    instr_fetch #(.RESET_PC(RST_PC)) dut (
        .clk       (clk),
        .reset     (reset),
        .pc_in     (pc_in),
        .pc_load   (pc_load),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .ir_out    (ir_out),
        .ir_pc     (ir_pc),
        .pc_plus4  (pc_plus4),
        .opcode_ir (opcode_ir),
        .rs_ir     (rs_ir),
        .rt_ir     (rt_ir),
        .rd_ir     (rd_ir),
        .shamt_ir  (shamt_ir),
        .funct_ir  (funct_ir),
        .imm16_ir  (imm16_ir),
        .target_ir (target_ir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a just-reset flag, an outstanding request (with a
    // "drop its data" flag), and an IR slot that is either full or empty.
    bit          m_boot;
    bit          m_req;
    bit          m_drop;
    bit          m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    logic [31:0] m_ir;
    logic [31:0] m_irpc;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic model_step(input bit rst, input bit ld, input logic [31:0] pin,
                              input bit ack, input logic [31:0] rd, input bit rdy);
        logic [31:0] tgt;
        tgt = pin & 32'hFFFF_FFFC;
        if (rst) begin
            m_boot = 1; m_req = 0; m_drop = 0; m_valid = 0;
            m_pc = RST_PC; m_addr = RST_PC; m_ir = 0; m_irpc = 0;
        end else if (m_boot) begin
            m_boot = 0;
            if (ld) m_pc = tgt;
            m_req = 1; m_drop = 0; m_addr = m_pc;
        end else if (m_valid) begin
            if (rdy || ld) begin
                m_valid = 0;
                if (ld) m_pc = tgt;
                m_req = 1; m_addr = m_pc;
            end
        end else if (m_req && !m_drop) begin
            if (ack && !ld) begin
                m_ir = rd; m_irpc = m_addr; m_pc = m_addr + 32'd4;
                m_req = 0; m_valid = 1;
            end else if (ack) begin
                m_pc = tgt; m_addr = tgt;
            end else if (ld) begin
                m_pc = tgt; m_drop = 1;
            end
        end else if (m_req) begin
            if (ld) m_pc = tgt;
            if (ack) begin
                m_drop = 0; m_addr = m_pc;
            end
        end
    endtask

    task automatic compare_all();
        check("mem_req", {31'b0, mem_req}, {31'b0, m_req});
        if (m_req) check("mem_addr", mem_addr, m_addr);
        check("ir_valid", {31'b0, ir_valid}, {31'b0, m_valid});
        check("ir_out", ir_out, m_ir);
        check("ir_pc", ir_pc, m_irpc);
        check("pc_plus4", pc_plus4, m_irpc + 32'd4);
        check("fields", {opcode_ir, rs_ir, rt_ir, rd_ir, shamt_ir, funct_ir}, m_ir);
        check("imm16", {16'b0, imm16_ir}, m_ir & 32'h0000_FFFF);
        check("target", {6'b0, target_ir}, m_ir & 32'h03FF_FFFF);
    endtask

    task automatic tick(input bit rst, input bit ld, input logic [31:0] pin,
                        input bit ack, input logic [31:0] rd, input bit rdy);
        reset = rst; pc_load = ld; pc_in = pin;
        mem_ack = ack; mem_rdata = rd; ir_ready = rdy;
        model_step(rst, ld, pin, ack, rd, rdy);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        bit          r_rst, r_ld, r_ack, r_rdy;
        logic [31:0] r_pin, r_rd;

        reset = 1'b1; pc_load = 1'b0; pc_in = '0;
        mem_ack = 1'b0; mem_rdata = '0; ir_ready = 1'b0;

        // Reset state
        tick(1, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_ir_valid", {31'b0, ir_valid}, 32'd0);
        check("rst_ir_out", ir_out, 32'd0);
        check("rst_opcode", {26'b0, opcode_ir}, 32'd0);

        // Zero-wait memory, downstream always ready
        tick(0, 0, 0, 0, 0, 1);
        check("zw_addr0", mem_addr, 32'h0);
        tick(0, 0, 0, 1, 32'hA000_0000, 1);
        check("zw_valid0", {31'b0, ir_valid}, 32'd1);
        tick(0, 0, 0, 0, 0, 1);
        check("zw_addr4", mem_addr, 32'h4);
        check("zw_gap", {31'b0, ir_valid}, 32'd0);
        tick(0, 0, 0, 1, 32'hA000_0004, 1);
        check("zw_irpc4", ir_pc, 32'h4);
        tick(0, 0, 0, 0, 0, 1);
        check("zw_addr8", mem_addr, 32'h8);
        tick(0, 0, 0, 1, 32'hA000_0008, 1);
        check("zw_irpc8", ir_pc, 32'h8);
        tick(0, 0, 0, 0, 0, 1);

        // Slow memory, then a stalled downstream
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 0, 0, 0);
            check("slow_addr", mem_addr, 32'hC);
        end
        tick(0, 0, 0, 1, 32'h1234_5678, 0);
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 0, 0, 0);
            check("stall_ir", ir_out, 32'h1234_5678);
            check("stall_req", {31'b0, mem_req}, 32'd0);
        end
        tick(0, 0, 0, 0, 0, 1);

        // Redirect before ack: flush the stale request
        tick(0, 1, 32'h0000_0103, 0, 0, 0);
        check("flush_old_addr", mem_addr, 32'h10);
        tick(0, 0, 0, 1, 32'hDEAD_BEEF, 0);
        check("flush_new_addr", mem_addr, 32'h100);
        check("flush_no_valid", {31'b0, ir_valid}, 32'd0);
        tick(0, 0, 0, 1, 32'h0000_0100, 0);
        check("flush_ir_pc", ir_pc, 32'h100);

        // Redirect in HOLD, with and without handoff
        tick(0, 1, 32'h0000_0200, 0, 0, 1);
        check("hold_ld_rdy_addr", mem_addr, 32'h200);
        tick(0, 0, 0, 1, 32'h0000_0200, 0);
        tick(0, 1, 32'h0000_0301, 0, 0, 0);
        check("squash_valid", {31'b0, ir_valid}, 32'd0);
        check("squash_addr", mem_addr, 32'h300);

        // Top-of-memory wrap and field decode
        tick(0, 1, 32'hFFFF_FFFC, 1, 32'hDEAD_BEEF, 0);
        check("wrap_addr", mem_addr, 32'hFFFF_FFFC);
        tick(0, 0, 0, 1, 32'h2108_FFFF, 0);
        check("wrap_imm16", {16'b0, imm16_ir}, 32'h0000_FFFF);
        check("wrap_rt", {27'b0, rt_ir}, 32'd8);
        check("wrap_opcode", {26'b0, opcode_ir}, 32'h08);
        check("wrap_plus4", pc_plus4, 32'h0);
        tick(0, 0, 0, 0, 0, 1);
        check("wrap_next", mem_addr, 32'h0);

        // Reset during FLUSH and a stray ack in IDLE
        tick(0, 1, 32'h0000_0040, 0, 0, 0);
        tick(1, 0, 0, 1, 32'hBAD0_BAD0, 0);
        check("rst_flush_req", {31'b0, mem_req}, 32'd0);
        tick(0, 0, 0, 1, 32'hBAD1_BAD1, 0);
        check("stray_addr", mem_addr, RST_PC);
        check("stray_valid", {31'b0, ir_valid}, 32'd0);
        tick(0, 0, 0, 1, 32'h5555_AAAA, 1);
        check("stray_ir", ir_out, 32'h5555_AAAA);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r_rst = ($urandom_range(0, 199) == 0);
            r_ld  = ($urandom_range(0, 7) == 0);
            r_pin = $urandom;
            r_ack = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            r_rd  = $urandom;
            r_rdy = ($urandom_range(0, 2) != 0);
            tick(r_rst, r_ld, r_pin, r_ack, r_rd, r_rdy);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
